// File: rtl/spawnin_reader_if.sv
// Bus bundle for spawnin_reader: BRAM port toward the spawn-in ring plus the
// {tid, ptid} valid/ready stream toward the task-finish logic.
interface spawnin_reader_if;
  logic [31:0] mem_addr;
  logic        mem_en;
  logic [7:0]  mem_wr;
  logic [63:0] mem_din;
  logic [63:0] mem_dout;
  logic [63:0] out_tid;
  logic [63:0] out_ptid;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output mem_addr, mem_en, mem_wr, mem_din, out_tid, out_ptid, out_valid,
    input  mem_dout, out_ready
  );

  modport slave (
    input  mem_addr, mem_en, mem_wr, mem_din, out_tid, out_ptid, out_valid,
    output mem_dout, out_ready
  );
endinterface

// File: rtl/spawnin_reader.sv
// Spawn-in ring consumer: polls 3-word entries, frees the slot, streams {tid, ptid}.
// Optional macro SPAWNIN_POLL_BACKOFF_EN idles the BRAM port between failed polls.
module spawnin_reader #(
  parameter int         SPAWNIN_SIZE  = 1024,
  parameter logic [7:0] EXPECTED_TYPE = 8'h01,
  parameter int         POLL_INTERVAL = 16
) (
  input  logic              clk,
  input  logic              rst,
  spawnin_reader_if.master  bus,
  output logic              err_type,
  output logic [31:0]       consumed_cnt
);

  localparam int B = $clog2(SPAWNIN_SIZE);

  if (SPAWNIN_SIZE < 4 || (SPAWNIN_SIZE & (SPAWNIN_SIZE - 1)) != 0 || POLL_INTERVAL < 1)
  begin : g_bad_param
    $error("spawnin_reader: SPAWNIN_SIZE must be a power of 2 >= 4, POLL_INTERVAL >= 1");
  end

  typedef enum logic [2:0] {
    POLL_ISSUE,
    POLL_CHECK,
    RD_TID,
    RD_PTID,
    CLEAR,
`ifdef SPAWNIN_POLL_BACKOFF_EN
    BACKOFF,
`endif
    OUTPUT
  } state_t;

  state_t      state;
  logic [B-1:0] idx;
  logic [B-1:0] idx_p1, idx_p2, idx_p3;
  logic [31:0] addr_q;
  logic [7:0]  wr_q;
  logic        en_q;
  logic [63:0] tid_q, ptid_q;
  logic        valid_q;

`ifdef SPAWNIN_POLL_BACKOFF_EN
  localparam int CW = $clog2(POLL_INTERVAL + 1);
  logic [CW-1:0] backoff_cnt;
`endif

  // Ring arithmetic wraps naturally in B bits, so entries may straddle the end.
  assign idx_p1 = idx + B'(1);
  assign idx_p2 = idx + B'(2);
  assign idx_p3 = idx + B'(3);

  function automatic logic [31:0] word_addr(input logic [B-1:0] w);
    logic [31:0] a;
    a = '0;
    a[3 +: B] = w;
    return a;
  endfunction

  // NOTE: every register here is updated with <= so all of them see the
  // pre-edge values of each other; a blocking assignment would reorder the FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= POLL_ISSUE;
      idx          <= '0;
      addr_q       <= '0;
      wr_q         <= '0;
      en_q         <= 1'b1;
      tid_q        <= '0;
      ptid_q       <= '0;
      valid_q      <= 1'b0;
      err_type     <= 1'b0;
      consumed_cnt <= '0;
`ifdef SPAWNIN_POLL_BACKOFF_EN
      backoff_cnt  <= '0;
`endif
    end else begin
      case (state)
        POLL_ISSUE: state <= POLL_CHECK;

        POLL_CHECK: begin
          if (bus.mem_dout[63:56] == 8'h80) begin
            if (bus.mem_dout[7:0] != EXPECTED_TYPE) err_type <= 1'b1;
            addr_q <= word_addr(idx_p1);
            state  <= RD_TID;
          end else begin
`ifdef SPAWNIN_POLL_BACKOFF_EN
            en_q        <= 1'b0;
            backoff_cnt <= CW'(POLL_INTERVAL - 1);
            state       <= BACKOFF;
`else
            state <= POLL_CHECK;
`endif
          end
        end

        RD_TID: begin
          addr_q <= word_addr(idx_p2);
          state  <= RD_PTID;
        end

        RD_PTID: begin
          tid_q  <= bus.mem_dout;
          addr_q <= word_addr(idx);
          wr_q   <= 8'h80;
          state  <= CLEAR;
        end

        CLEAR: begin
          ptid_q  <= bus.mem_dout;
          wr_q    <= '0;
          valid_q <= 1'b1;
          state   <= OUTPUT;
        end

        OUTPUT: begin
          if (bus.out_ready) begin
            valid_q      <= 1'b0;
            idx          <= idx_p3;
            addr_q       <= word_addr(idx_p3);
            consumed_cnt <= consumed_cnt + 32'd1;
            state        <= POLL_ISSUE;
          end
        end

`ifdef SPAWNIN_POLL_BACKOFF_EN
        BACKOFF: begin
          if (backoff_cnt == '0) begin
            en_q  <= 1'b1;
            state <= POLL_ISSUE;
          end else begin
            backoff_cnt <= backoff_cnt - CW'(1);
          end
        end
`endif

        default: state <= POLL_ISSUE;
      endcase
    end
  end

  // Reset landing in the CLEAR cycle must suppress the header write, so the
  // registered strobe is gated by rst combinationally.
  assign bus.mem_wr    = rst ? 8'h00 : wr_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_en    = en_q;
  assign bus.mem_din   = '0;
  assign bus.out_tid   = tid_q;
  assign bus.out_ptid  = ptid_q;
  assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_spawnin_reader.sv
// Directed bench for spawnin_reader: BRAM model, vector table, reset and wrap
// sequences; backoff timing checked when SPAWNIN_POLL_BACKOFF_EN is defined.
module tb_spawnin_reader;
  localparam int SIZE = 1024;
  localparam int AW   = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        err_type;
  logic [31:0] consumed_cnt;

  spawnin_reader_if bus ();

  spawnin_reader #(
    .SPAWNIN_SIZE (SIZE),
    .EXPECTED_TYPE(8'h01),
    .POLL_INTERVAL(16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .err_type    (err_type),
    .consumed_cnt(consumed_cnt)
  );

  always #5 clk = ~clk;

  // Read-first BRAM with 1-cycle read latency and byte write enables.
  logic [63:0] mem [SIZE];
  always @(posedge clk) begin : bram
    int w;
    if (bus.mem_en) begin
      w = int'(bus.mem_addr[3 +: AW]);
      bus.mem_dout <= mem[w];
      for (int b = 0; b < 8; b++)
        if (bus.mem_wr[b]) mem[w][8*b +: 8] = bus.mem_din[8*b +: 8];
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic write_entry(input int at, input logic [63:0] hdr, tid, ptid);
    mem[(at + 1) % SIZE] = tid;
    mem[(at + 2) % SIZE] = ptid;
    mem[at % SIZE]       = hdr;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_valid(input int limit, output int cycles);
    cycles = 0;
    while (!bus.out_valid && cycles < limit) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic consume(input string name, input int at, input logic [63:0] hdr, tid, ptid,
                         input logic err, input int hold, input logic [31:0] exp_cnt);
    int  c;
    logic stable;
    bus.out_ready = (hold == 0);
    wait_valid(100, c);
    check({name, " valid"}, bus.out_valid, 1);
    check({name, " tid"}, bus.out_tid, tid);
    check({name, " ptid"}, bus.out_ptid, ptid);
    check({name, " err"}, err_type, err);
    check({name, " hdr_cleared"}, mem[at % SIZE], {8'h00, hdr[55:0]});
    if (hold > 0) begin
      stable = 1'b1;
      repeat (hold) begin
        @(negedge clk);
        if (!bus.out_valid || bus.out_tid !== tid || bus.out_ptid !== ptid) stable = 1'b0;
      end
      check({name, " stable"}, stable, 1);
      bus.out_ready = 1'b1;
    end
    @(negedge clk);
    check({name, " valid_drop"}, bus.out_valid, 0);
    check({name, " cnt"}, consumed_cnt, exp_cnt);
    bus.out_ready = 1'b0;
  endtask

  typedef struct {
    logic [63:0] hdr;
    logic [63:0] tid;
    logic [63:0] ptid;
    int          hold;
    logic        err;
  } vec_t;

  initial begin
    vec_t vecs [4];
    int   tb_idx;
    int   c, k, cyc, en_hi;
    logic moved;

    vecs[0] = '{64'h8000_0000_0000_0001, 64'h11, 64'h22, 0, 1'b0};
    vecs[1] = '{64'h8000_0000_0000_0001, 64'hAAAA_5555_0000_0001, 64'h1234_5678_9ABC_DEF0, 20, 1'b0};
    vecs[2] = '{64'h8000_0000_0000_0005, 64'h33, 64'h44, 0, 1'b1};
    vecs[3] = '{64'h8012_3400_0000_0001, 64'h55, 64'h66, 3, 1'b1};

    for (int i = 0; i < SIZE; i++) mem[i] = '0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst valid", bus.out_valid, 0);
    check("rst cnt", consumed_cnt, 0);
    check("rst err", err_type, 0);
    check("rst addr", bus.mem_addr, 0);
    check("rst wr", bus.mem_wr, 0);
    check("rst din", bus.mem_din, 0);
    check("rst en", bus.mem_en, 1);
    check("rst tid", bus.out_tid, 0);
    rst = 1'b0;

    // Table-driven entries, including held ready and a wrong-type header.
    tb_idx = 0;
    for (int i = 0; i < 4; i++) begin
      write_entry(tb_idx, vecs[i].hdr, vecs[i].tid, vecs[i].ptid);
      consume($sformatf("vec%0d", i), tb_idx, vecs[i].hdr, vecs[i].tid, vecs[i].ptid,
              vecs[i].err, vecs[i].hold, 32'(i + 1));
      tb_idx += 3;
    end

    // Header without the valid byte must not be consumed.
    mem[tb_idx] = 64'h4000_0000_0000_0001;
    moved = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus.out_valid || bus.mem_addr[3 +: AW] != AW'(tb_idx)) moved = 1'b1;
    end
    check("empty idle", moved, 0);
    check("empty cnt", consumed_cnt, 4);

    // Reset while an entry is being offered.
    write_entry(tb_idx, 64'h8000_0000_0000_0001, 64'h77, 64'h88);
    wait_valid(100, c);
    check("rstout valid_before", bus.out_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstout valid", bus.out_valid, 0);
    check("rstout cnt", consumed_cnt, 0);
    check("rstout addr", bus.mem_addr, 0);
    check("rstout err", err_type, 0);
    write_entry(0, 64'h8000_0000_0000_0001, 64'h99, 64'hAA);
    consume("fresh", 0, 64'h8000_0000_0000_0001, 64'h99, 64'hAA, 1'b0, 0, 1);

    // Reset coinciding with CLEAR: the header write must be suppressed.
    do_reset();
    write_entry(0, 64'h8000_0000_0000_0001, 64'hBB, 64'hCC);
    c = 0;
    while (bus.mem_wr != 8'h80 && c < 100) begin
      @(negedge clk);
      c++;
    end
    check("rstclr reached", bus.mem_wr, 8'h80);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstclr hdr_kept", mem[0], 64'h8000_0000_0000_0001);
    check("rstclr valid", bus.out_valid, 0);
    consume("rstclr redo", 0, 64'h8000_0000_0000_0001, 64'hBB, 64'hCC, 1'b0, 0, 1);

    // 342 entries; the last one straddles words 1023, 0, 1.
    do_reset();
    for (int i = 0; i < SIZE; i++) mem[i] = '0;
    for (int e = 0; e < 341; e++)
      write_entry(3 * e, 64'h8000_0000_0000_0001, 64'h1000 + 64'(e), 64'h2000 + 64'(e));
    bus.out_ready = 1'b1;
    k = 0;
    cyc = 0;
    while (k < 342 && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (k == 2 && mem[1023] == 64'h0)
        write_entry(1023, 64'h8000_0000_0000_0001, 64'h1000 + 64'd341, 64'h2000 + 64'd341);
      if (bus.out_valid) begin
        check($sformatf("wrap%0d tid", k), bus.out_tid, 64'h1000 + 64'(k));
        check($sformatf("wrap%0d ptid", k), bus.out_ptid, 64'h2000 + 64'(k));
        k++;
      end
    end
    @(negedge clk);
    check("wrap count", 64'(k), 342);
    check("wrap cnt", consumed_cnt, 342);
    check("wrap hdr1023", mem[1023], 64'h0000_0000_0000_0001);
    check("wrap err", err_type, 0);

    // Empty-ring BRAM activity and detection latency (ring now idles at word 2).
    repeat (20) @(negedge clk);
    en_hi = 0;
    repeat (36) begin
      @(negedge clk);
      if (bus.mem_en) en_hi++;
    end
`ifdef SPAWNIN_POLL_BACKOFF_EN
    check("backoff en_high", 64'(en_hi), 4);
`else
    check("poll en_high", 64'(en_hi), 36);
`endif
    write_entry(2, 64'h8000_0000_0000_0001, 64'hCAFE, 64'hBEEF);
`ifdef SPAWNIN_POLL_BACKOFF_EN
    wait_valid(22, c);
`else
    wait_valid(6, c);
`endif
    check("late valid", bus.out_valid, 1);
    check("late tid", bus.out_tid, 64'hCAFE);
    check("late ptid", bus.out_ptid, 64'hBEEF);
    @(negedge clk);
    check("late cnt", consumed_cnt, 343);
    bus.out_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
